// File: rtl/visitor_count_ctrl_pkg.sv
// Shared types and constants for the bit-serial visitor counter.
package visitor_count_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERIAL = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IN  = 1'b0,
    GNT_OUT = 1'b1
  } gnt_e;

endpackage

// File: rtl/half_adder.sv
// Team half-adder cell: single-bit sum and carry.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/visitor_count_ctrl.sv
// Visitor counter: entry/exit strobes are queued, arbitrated round-robin and
// applied to the count one bit per cycle through a single shared half-adder.
module visitor_count_ctrl
  import visitor_count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_pls,
  input  logic             exit_pls,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             rejected,
  output logic             dropped,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               c_q, c_d;
  logic               pend_in_q, pend_in_d;
  logic               pend_out_q, pend_out_d;
  gnt_e               last_gnt_q, last_gnt_d;
  gnt_e               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rejected_q, rejected_d;
  logic               dropped_q, dropped_d;

  logic               clr_in, clr_out;
  logic               grant_in;
  logic               inc;
  logic               ha_a, ha_sum, ha_carry;
  logic               res_bit;
  logic               full_c, empty_c;

  assign full_c  = (count_q == {WIDTH{1'b1}});
  assign empty_c = (count_q == '0);

  // Decrement reuses the incrementer by complementing the operand and result.
  assign inc     = (dir_q == GNT_IN);
  assign ha_a    = inc ? shreg_q[0] : ~shreg_q[0];
  assign res_bit = inc ? ha_sum : ~ha_sum;

  half_adder u_ha (
    .a     (ha_a),
    .b     (c_q),
    .sum   (ha_sum),
    .carry (ha_carry)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    c_d        = c_q;
    last_gnt_d = last_gnt_q;
    dir_d      = dir_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rejected_d = 1'b0;
    clr_in     = 1'b0;
    clr_out    = 1'b0;
    grant_in   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_in_q || pend_out_q) begin
          if (pend_in_q && pend_out_q) grant_in = (last_gnt_q == GNT_OUT);
          else                         grant_in = pend_in_q;
          dir_d      = grant_in ? GNT_IN : GNT_OUT;
          last_gnt_d = dir_d;
          clr_in     = grant_in;
          clr_out    = ~grant_in;
          busy_d     = 1'b1;
          if ((grant_in && full_c) || (!grant_in && empty_c)) begin
            state_d    = DONE;
            done_d     = 1'b1;
            rejected_d = 1'b1;
          end else begin
            state_d = SERIAL;
            shreg_d = count_q;
            c_d     = 1'b1;
            idx_d   = '0;
          end
        end
      end
      SERIAL: begin
        shreg_d = {res_bit, shreg_q[WIDTH-1:1]};
        c_d     = ha_carry;
        idx_d   = idx_q + IDX_W'(1);
        busy_d  = 1'b1;
        if (idx_q == IDX_W'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!rejected_q) count_d = shreg_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new strobe re-sets a flag cleared by the same-cycle grant.
  assign pend_in_d  = (pend_in_q & ~clr_in) | entry_pls;
  assign pend_out_d = (pend_out_q & ~clr_out) | exit_pls;
  assign dropped_d  = (entry_pls & pend_in_q & ~clr_in) |
                      (exit_pls & pend_out_q & ~clr_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shreg_q    <= '0;
      idx_q      <= '0;
      c_q        <= 1'b0;
      pend_in_q  <= 1'b0;
      pend_out_q <= 1'b0;
      last_gnt_q <= GNT_OUT;
      dir_q      <= GNT_IN;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rejected_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      c_q        <= c_d;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      last_gnt_q <= last_gnt_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rejected_q <= rejected_d;
      dropped_q  <= dropped_d;
    end
  end

  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rejected = rejected_q;
  assign dropped  = dropped_q;
  assign full     = full_c;
  assign empty    = empty_c;

endmodule

// File: tb/tb_visitor_count_ctrl.sv
// Directed self-checking bench for visitor_count_ctrl (WIDTH=8).
module tb_visitor_count_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         entry_pls = 1'b0;
  logic         exit_pls = 1'b0;
  logic [W-1:0] count;
  logic         busy, done, rejected, dropped, full, empty;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  visitor_count_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .entry_pls (entry_pls),
    .exit_pls  (exit_pls),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .rejected  (rejected),
    .dropped   (dropped),
    .full      (full),
    .empty     (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Pulse counters, plus the final carry/borrow of every committed update must be 0.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dropped) drop_cnt++;
    if (done && !rejected) check("carry_out_zero", 32'(dut.c_q), 32'd0);
  end

  task automatic pulse(input logic e, input logic x);
    @(negedge clk); entry_pls = e; exit_pls = x;
    @(negedge clk); entry_pls = 1'b0; exit_pls = 1'b0;
  endtask

  task automatic run_op(input logic e, input logic x);
    int t;
    pulse(e, x);
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 40);
    if (!done) check("op_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic step_to(input int target);
    for (int i = exp_cnt; i < target; i++) run_op(1'b1, 1'b0);
    exp_cnt = target;
    check("step_count", 32'(count), 32'(target));
  endtask

  initial begin
    int d0;
    int dr0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rejected", 32'(rejected), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;

    // Exit at empty is refused one cycle after grant
    pulse(1'b0, 1'b1);
    @(negedge clk);
    check("rej_empty_busy", 32'(busy), 32'd1);
    check("rej_empty_done", 32'(done), 32'd1);
    check("rej_empty_rejected", 32'(rejected), 32'd1);
    @(negedge clk);
    check("rej_empty_idle", 32'(busy), 32'd0);
    check("rej_empty_count", 32'(count), 32'd0);
    check("rej_empty_pulse_end", 32'(rejected), 32'd0);

    // Single entry: busy 9 cycles, done on the 9th, count=1 at grant+9
    pulse(1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("inc1_busy", 32'(busy), 32'd1);
      check("inc1_done", 32'(done), (k == 9) ? 32'd1 : 32'd0);
      check("inc1_count_hold", 32'(count), 32'd0);
    end
    @(negedge clk);
    check("inc1_busy_end", 32'(busy), 32'd0);
    check("inc1_count", 32'(count), 32'd1);
    exp_cnt = 1;

    // Simultaneous entry/exit at 5 after an exit grant: entry first, then exit
    step_to(6);
    run_op(1'b0, 1'b1);
    exp_cnt = 5;
    check("pre_rr_count", 32'(count), 32'd5);
    d0 = done_cnt;
    pulse(1'b1, 1'b1);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 10) begin
        check("rr_first_count", 32'(count), 32'd6);
        check("rr_gap_idle", 32'(busy), 32'd0);
      end
      if (k == 11) check("rr_second_busy", 32'(busy), 32'd1);
      if (k == 20) check("rr_second_count", 32'(count), 32'd5);
    end
    check("rr_done_pulses", 32'(done_cnt - d0), 32'd2);
    check("rr_idle", 32'(busy), 32'd0);

    // 0x0F -> 0x10: carry ripples through bits 0..3 and dies at bit 4
    step_to(15);
    pulse(1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("ripple_carry", 32'(dut.c_q), (k <= 5) ? 32'd1 : 32'd0);
      check("ripple_count_hold", 32'(count), 32'h0F);
    end
    @(negedge clk);
    check("ripple_count", 32'(count), 32'h10);
    exp_cnt = 16;

    // Entry during SERIAL is queued; a repeat while pending is dropped
    d0 = done_cnt;
    dr0 = drop_cnt;
    pulse(1'b1, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      entry_pls = (k == 3 || k == 4);
      if (k == 5) check("drop_pulse", 32'(dropped), 32'd1);
      if (k == 10) check("queue_first_count", 32'(count), 32'h11);
      if (k == 20) check("queue_second_count", 32'(count), 32'h12);
    end
    check("queue_done_pulses", 32'(done_cnt - d0), 32'd2);
    check("queue_drop_pulses", 32'(drop_cnt - dr0), 32'd1);
    check("queue_idle", 32'(busy), 32'd0);
    exp_cnt = 18;

    // Fill to 0xFF, then entry is refused
    step_to(255);
    check("full_flag", 32'(full), 32'd1);
    check("full_empty_flag", 32'(empty), 32'd0);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    check("rej_full_done", 32'(done), 32'd1);
    check("rej_full_rejected", 32'(rejected), 32'd1);
    @(negedge clk);
    check("rej_full_count", 32'(count), 32'hFF);
    check("rej_full_idle", 32'(busy), 32'd0);

    // Reset during SERIAL bit 3 aborts without commit
    pulse(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    check("abort_bit_index", 32'(dut.idx_q), 32'd3);
    rst_n = 1'b0;
    #1;
    check("abort_count", 32'(count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_count_after", 32'(count), 32'd0);
    check("abort_idle_after", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/visitor_count_ctrl.md
VISITOR_COUNT_CTRL -- requirements
Module: visitor_count_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of the visitor count.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 The block SHALL have port entry_pls, input, 1, a one-cycle strobe per person entering.
REQ-005 The block SHALL have port exit_pls, input, 1, a one-cycle strobe per person leaving.
REQ-006 The block SHALL have port count, output, WIDTH, the registered visitor count.
REQ-007 The block SHALL have port busy, output, 1, high while a serial update is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse when a count update commits.
REQ-009 The block SHALL have port rejected, output, 1, a one-cycle pulse when a request is refused (increment at full or decrement at empty).
REQ-010 The block SHALL have port dropped, output, 1, a one-cycle pulse when a strobe arrives while the same-direction pending flag is already set.
REQ-011 The block SHALL have ports full and empty, output, 1 each, combinational from count: full is count == all-ones and empty is count == 0.

Function
REQ-012 The block SHALL latch each strobe into a pending flag (pend_in or pend_out); a strobe in the same cycle as its flag is cleared SHALL set the flag again (set wins).
REQ-013 The FSM SHALL have states IDLE, SERIAL and DONE.
REQ-014 In IDLE with no pending flag, the FSM SHALL stay in IDLE with busy=0.
REQ-015 In IDLE with exactly one flag pending, that request SHALL be granted.
REQ-016 In IDLE with both flags pending, grant SHALL alternate round-robin; the last-grant flag resets to "exit", so entry wins first after reset.
REQ-017 A grant SHALL clear its pending flag on the grant edge.
REQ-018 A valid grant SHALL load the shift register with count, set carry/borrow to 1, set the bit index to 0, and go to SERIAL.
REQ-019 An invalid grant (entry with full, exit with empty) SHALL go directly to DONE, assert rejected in DONE, and leave count unchanged.
REQ-020 In SERIAL, the block SHALL process one bit per cycle, LSB first, through a single shared half-adder.
REQ-021 For increment: sum = bit XOR c and carry = bit AND c.
REQ-022 For decrement, the half-adder SHALL be fed with ~bit: diff = ~sum and borrow = carry.
REQ-023 Each result bit SHALL be shifted in at the MSB, and the carry/borrow SHALL be registered for the next bit.
REQ-024 SERIAL SHALL last exactly WIDTH cycles and then transition to DONE.
REQ-025 In DONE, count SHALL take the result, done SHALL pulse (with rejected for invalid grants), and the FSM SHALL return to IDLE on the next edge.
REQ-026 Latency from the grant edge to the count update SHALL be WIDTH+1 cycles for a valid request and 1 cycle for a rejected one.
REQ-027 Strobes arriving during SERIAL or DONE SHALL only set pending flags and SHALL NOT disturb the in-flight operation.
REQ-028 count SHALL hold its old value until the DONE commit edge.
REQ-029 The final carry/borrow out of SERIAL SHALL always be 0; a bench assertion SHALL flag any nonzero value.
REQ-030 busy SHALL be 1 in SERIAL and DONE, and 0 in IDLE.

Reset
REQ-031 Assertion of rst_n low SHALL asynchronously force: state=IDLE; count, shift register, bit index, carry, pend_in and pend_out to 0; last-grant to "exit"; busy, done, rejected and dropped to 0.
REQ-032 Reset asserted during SERIAL SHALL abort the operation with no partial commit to count.
REQ-033 Deassertion of rst_n SHALL take effect on the next clk edge.

Structure
REQ-034 A shared package SHALL hold the FSM state typedef, the grant-direction encoding (GNT_IN, GNT_OUT) and the default WIDTH constant.
REQ-035 The block SHALL instantiate exactly one half_adder sub-module, the existing team cell with ports carry, sum, a, b, as its only arithmetic element.

Verification
REQ-036 The bench SHALL cover: reset, then one entry_pls -> busy for 9 cycles, done pulse, count=1 at grant+9 (WIDTH=8).
REQ-037 The bench SHALL cover: count=8'h0F, entry_pls -> count=8'h10, full carry propagation through bit 4 checked per cycle.
REQ-038 The bench SHALL cover: count=0, exit_pls -> rejected and done pulse 1 cycle after grant, count stays 0; count=8'hFF, entry_pls -> rejected, count stays 8'hFF.
REQ-039 The bench SHALL cover: entry_pls and exit_pls in the same cycle at count=5 -> entry served first (count=6), then exit (count=5), two done pulses.
REQ-040 The bench SHALL cover: second entry_pls during SERIAL -> pending honoured after first commit; third entry_pls while pend_in is set -> dropped pulse, final count +2 only.
REQ-041 The bench SHALL cover: rst_n low at SERIAL bit 3 -> count=0, busy=0 immediately, no done pulse.
